cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 133 +++++++++++++
 tb/tb_cdb_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: fixed-latency ALU/branch results first, then round-robin over variable-latency FUs.
// Optional starvation guard enabled by defining CDB_ARB_STARVE_GUARD_EN.
module cdb_arbiter #(
    parameter int N             = 2,
    parameter int NUM_FU_ALU    = 2,
    parameter int NUM_FU_BRANCH = 1,
    parameter int NUM_FU_MULT   = 2,
    parameter int NUM_FU_LDST   = 1,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                                                               clock,
    input  logic                                                               reset,
    input  logic [NUM_FU_ALU-1:0]                                              alu_issue_valid,
    input  logic [NUM_FU_BRANCH-1:0]                                           branch_issue_valid,
    input  logic [NUM_FU_MULT-1:0]                                             mult_cdb_valid,
    input  logic [NUM_FU_LDST-1:0]                                             ldst_cdb_valid,
    output logic [N*(NUM_FU_LDST+NUM_FU_MULT+NUM_FU_ALU+NUM_FU_BRANCH)-1:0]    complete_gnt_bus,
    output logic [NUM_FU_MULT-1:0]                                             mult_cdb_en,
    output logic [NUM_FU_LDST-1:0]                                             ldst_cdb_en,
    output logic [$clog2(N+1)-1:0]                                             fixed_issue_slots,
    output logic                                                               arb_overflow_err
);
    localparam int V     = NUM_FU_LDST + NUM_FU_MULT;
    localparam int F     = NUM_FU_ALU + NUM_FU_BRANCH;
    localparam int TOTAL = V + F;
    localparam int PW    = (V > 1) ? $clog2(V) : 1;
    localparam int SW    = $clog2(N + 1);

    logic [F-1:0]     pending_fixed_reg;
    logic [V-1:0]     var_req;
    logic [V-1:0]     var_gnt;
    logic [V-1:0]     starving;
    logic [PW-1:0]    rr_ptr_reg;
    logic [PW-1:0]    rr_ptr_next;
    logic             overflow_now;
    logic             overflow_err_reg;
    logic [TOTAL-1:0] gnt [N];

    assign var_req = {mult_cdb_valid, ldst_cdb_valid};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_fixed_reg <= '0;
            rr_ptr_reg        <= '0;
            overflow_err_reg  <= 1'b0;
        end else begin
            pending_fixed_reg <= {branch_issue_valid, alu_issue_valid};
            rr_ptr_reg        <= rr_ptr_next;
            overflow_err_reg  <= overflow_err_reg | overflow_now;
        end
    end

    // Grants are gated by reset so outputs drop immediately even while requests stay high.
    always_comb begin
        int slot;
        int idx;
        int last;
        for (int s = 0; s < N; s++) gnt[s] = '0;
        var_gnt      = '0;
        slot         = 0;
        idx          = 0;
        last         = -1;
        overflow_now = 1'b0;
        if (reset) begin
            overflow_now = ($countones(pending_fixed_reg) > N);
            for (int i = 0; i < F; i++) begin
                if (pending_fixed_reg[i] && slot < N) begin
                    for (int s = 0; s < N; s++) if (s == slot) gnt[s][V+i] = 1'b1;
                    slot++;
                end
            end
            // At most one starving FU jumps the queue; the rest fall back to round-robin.
            for (int j = 0; j < V; j++) begin
                if (starving[j] && var_req[j] && last < 0 && slot < N) begin
                    for (int s = 0; s < N; s++) if (s == slot) gnt[s][j] = 1'b1;
                    var_gnt[j] = 1'b1;
                    last       = j;
                    slot++;
                end
            end
            for (int k = 0; k < V; k++) begin
                idx = (int'(rr_ptr_reg) + k) % V;
                for (int j = 0; j < V; j++) begin
                    if (j == idx && var_req[j] && !var_gnt[j] && slot < N) begin
                        for (int s = 0; s < N; s++) if (s == slot) gnt[s][j] = 1'b1;
                        var_gnt[j] = 1'b1;
                        last       = j;
                        slot++;
                    end
                end
            end
        end
        rr_ptr_next = (last >= 0) ? PW'((last + 1) % V) : rr_ptr_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign complete_gnt_bus[gi*TOTAL +: TOTAL] = gnt[gi];
        end
    endgenerate

    assign ldst_cdb_en      = var_gnt[NUM_FU_LDST-1:0];
    assign mult_cdb_en      = var_gnt[V-1:NUM_FU_LDST];
    assign arb_overflow_err = reset & (overflow_err_reg | overflow_now);

`ifdef CDB_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    generate
        for (gi = 0; gi < V; gi++) begin : g_starve
            logic [CW-1:0] cnt_reg;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    cnt_reg <= '0;
                end else if (!var_req[gi] || var_gnt[gi]) begin
                    cnt_reg <= '0;
                end else if (cnt_reg != CW'(STARVE_LIMIT)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign starving[gi] = (cnt_reg >= CW'(STARVE_LIMIT));
        end
    endgenerate

    // Reserve one slot for a starving FU by throttling fixed-latency issue.
    assign fixed_issue_slots = (reset && (|starving)) ? SW'(N - 1) : SW'(N);
`else
    assign starving          = '0;
    assign fixed_issue_slots = SW'(N);
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic against a list-based reference model.
module tb_cdb_arbiter;
    localparam int N   = 2;
    localparam int V   = 3;
    localparam int F   = 3;
    localparam int TOT = 6;
    localparam int LIM = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  alu_issue_valid = '0;
    logic        branch_issue_valid = 1'b0;
    logic [1:0]  mult_cdb_valid = '0;
    logic        ldst_cdb_valid = 1'b0;
    logic [11:0] complete_gnt_bus;
    logic [1:0]  mult_cdb_en;
    logic        ldst_cdb_en;
    logic [1:0]  fixed_issue_slots;
    logic        arb_overflow_err;

    cdb_arbiter dut (
        .clock              (clock),
        .reset              (reset),
        .alu_issue_valid    (alu_issue_valid),
        .branch_issue_valid (branch_issue_valid),
        .mult_cdb_valid     (mult_cdb_valid),
        .ldst_cdb_valid     (ldst_cdb_valid),
        .complete_gnt_bus   (complete_gnt_bus),
        .mult_cdb_en        (mult_cdb_en),
        .ldst_cdb_en        (ldst_cdb_en),
        .fixed_issue_slots  (fixed_issue_slots),
        .arb_overflow_err   (arb_overflow_err)
    );

    always #5 clock = ~clock;

    int total  = 0;
    int passed = 0;
    int step_no = 0;

    // Reference model state: pending fixed results as {br0, alu1, alu0}, rotating pointer, sticky error.
    logic [2:0] m_pend = '0;
    int         m_rr   = 0;
    logic       m_err  = 1'b0;
`ifdef CDB_ARB_STARVE_GUARD_EN
    int         m_cnt [V] = '{0, 0, 0};
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] a, input logic b, input logic [1:0] m,
                        input logic l, input string tag, output logic [2:0] vg);
        logic [11:0] e_bus;
        logic [2:0]  req;
        logic        e_ovf;
        logic [1:0]  e_slots;
        int          last;
        int          j;
        int          granted[$];
        @(negedge clock);
        reset              = r;
        alu_issue_valid    = a;
        branch_issue_valid = b;
        mult_cdb_valid     = m;
        ldst_cdb_valid     = l;
        #1;
        step_no++;
        req     = {m, l};
        e_bus   = '0;
        vg      = '0;
        last    = -1;
        e_ovf   = 1'b0;
        e_slots = 2'd2;
        if (r) begin
            for (int f = 0; f < F; f++)
                if (m_pend[f] && granted.size() < N) granted.push_back(V + f);
            e_ovf = ($countones(m_pend) > N);
`ifdef CDB_ARB_STARVE_GUARD_EN
            for (int q = 0; q < V; q++) begin
                if (m_cnt[q] >= LIM) e_slots = 2'd1;
                if (req[q] && m_cnt[q] >= LIM && last < 0 && granted.size() < N) begin
                    granted.push_back(q);
                    vg[q] = 1'b1;
                    last  = q;
                end
            end
`endif
            for (int k = 0; k < V; k++) begin
                j = (m_rr + k) % V;
                if (req[j] && !vg[j] && granted.size() < N) begin
                    granted.push_back(j);
                    vg[j] = 1'b1;
                    last  = j;
                end
            end
            foreach (granted[s]) e_bus[s*TOT + granted[s]] = 1'b1;
        end else begin
            m_pend = '0;
            m_rr   = 0;
            m_err  = 1'b0;
`ifdef CDB_ARB_STARVE_GUARD_EN
            for (int q = 0; q < V; q++) m_cnt[q] = 0;
`endif
        end
        check({tag, "_bus"},   64'(complete_gnt_bus),  64'(e_bus));
        check({tag, "_mult"},  64'(mult_cdb_en),       64'(vg[2:1]));
        check({tag, "_ldst"},  64'(ldst_cdb_en),       64'(vg[0]));
        check({tag, "_slots"}, 64'(fixed_issue_slots), 64'(e_slots));
        check({tag, "_err"},   64'(arb_overflow_err),  64'(r & (m_err | e_ovf)));
        $display("step %0d %s rst=%b alu=%b br=%b mult=%b ldst=%b gnt=%b_%b en=%b/%b slots=%0d err=%b",
                 step_no, tag, r, a, b, m, l, complete_gnt_bus[11:6], complete_gnt_bus[5:0],
                 mult_cdb_en, ldst_cdb_en, fixed_issue_slots, arb_overflow_err);
        if (r) begin
            m_err = m_err | e_ovf;
            if (last >= 0) m_rr = (last + 1) % V;
`ifdef CDB_ARB_STARVE_GUARD_EN
            for (int q = 0; q < V; q++)
                m_cnt[q] = (req[q] && !vg[q]) ? ((m_cnt[q] < LIM) ? m_cnt[q] + 1 : LIM) : 0;
`endif
            m_pend = {b, a};
        end
    endtask

    logic [2:0] vg;
    logic [2:0] hold;
    logic [1:0] ra;
    logic       rb;

    initial begin
        // Reset state, then the documented scenarios.
        step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, "reset", vg);
        step(1'b1, 2'b11, 1'b0, 2'b00, 1'b0, "issue2", vg);
        step(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, "fixed2", vg);
        check("fixed2_lit", 64'(complete_gnt_bus), 64'(12'b010000_001000));
        step(1'b1, 2'b00, 1'b0, 2'b11, 1'b1, "mix_rr0", vg);
        check("mix_rr0_lit", 64'(complete_gnt_bus), 64'(12'b000001_001000));
        check("mix_rr0_ldst", 64'(ldst_cdb_en), 64'(1));
        step(1'b1, 2'b00, 1'b0, 2'b11, 1'b1, "var_rr1", vg);
        check("var_rr1_lit", 64'(complete_gnt_bus), 64'(12'b000100_000010));
        check("var_rr1_mult", 64'(mult_cdb_en), 64'(2'b11));
        step(1'b1, 2'b11, 1'b1, 2'b11, 1'b1, "var_rr0", vg);
        check("var_rr0_lit", 64'(complete_gnt_bus), 64'(12'b000010_000001));
        step(1'b1, 2'b00, 1'b0, 2'b10, 1'b0, "overflow", vg);
        check("overflow_lit", 64'(complete_gnt_bus), 64'(12'b010000_001000));
        check("overflow_err", 64'(arb_overflow_err), 64'(1));
        step(1'b1, 2'b00, 1'b0, 2'b10, 1'b0, "sticky", vg);
        check("sticky_err", 64'(arb_overflow_err), 64'(1));
        step(1'b1, 2'b11, 1'b0, 2'b01, 1'b0, "traffic", vg);
        step(1'b0, 2'b00, 1'b0, 2'b11, 1'b1, "midreset", vg);
        check("midreset_lit", 64'(complete_gnt_bus), 64'(0));
        check("midreset_slots", 64'(fixed_issue_slots), 64'(2));
        step(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, "release", vg);
        check("release_lit", 64'(complete_gnt_bus), 64'(0));
`ifdef CDB_ARB_STARVE_GUARD_EN
        step(1'b1, 2'b11, 1'b0, 2'b00, 1'b0, "g_pre", vg);
        for (int c = 0; c < 4; c++) step(1'b1, 2'b11, 1'b0, 2'b01, 1'b0, "g_deny", vg);
        step(1'b1, 2'b01, 1'b0, 2'b01, 1'b0, "g_starve", vg);
        check("g_starve_slots", 64'(fixed_issue_slots), 64'(1));
        step(1'b1, 2'b00, 1'b0, 2'b01, 1'b0, "g_grant", vg);
        check("g_grant_lit", 64'(complete_gnt_bus), 64'(12'b000010_001000));
        step(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, "g_after", vg);
        check("g_after_slots", 64'(fixed_issue_slots), 64'(2));
`endif
        // Randomized traffic: variable requests are held until granted.
        hold = '0;
        for (int c = 0; c < 300; c++) begin
            hold = hold | 3'($urandom_range(0, 7) & $urandom_range(0, 7));
            ra   = 2'($urandom_range(0, 3));
            rb   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) != 0 && ra == 2'b11) rb = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                step(1'b0, ra, rb, hold[2:1], hold[0], "rnd_rst", vg);
                hold = '0;
            end else begin
                step(1'b1, ra, rb, hold[2:1], hold[0], "rnd", vg);
                hold = hold & ~vg;
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
